// File: rtl/toggle_rx_mac.sv
// toggle_rx_mac: clk_B-side receiver for a toggle-handshake operand bus.
// Each transition of the synchronized request toggle accepts one (a_in, b_in)
// pair. The pair is multiplied, and the product is accumulated with saturation
// over frame_len pairs. One acknowledge toggle is returned per accepted pair.
//
// Ports:
//   clk_B      receive-domain clock
//   rst_n      asynchronous active-low reset
//   req_sync   synchronized request toggle; each edge announces one new pair
//   a_in,b_in  bundled operands; stable while the request is outstanding
//   frame_len  pairs per result, sampled on the first pair of a frame (0 -> 1)
//   ack_tgl    acknowledge toggle, flips once per accepted pair
//   acc_out    last frame result, held until the next frame completes
//   acc_valid  one-cycle pulse when acc_out updates
//   acc_sat    set with acc_out if any saturation occurred in that frame
//   busy       high while a pair is being multiplied/accumulated
module toggle_rx_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk_B,
  input  logic              rst_n,
  input  logic              req_sync,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [CNT_W-1:0]  frame_len,
  output logic              ack_tgl,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              acc_sat,
  output logic              busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_last_q, req_last_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                ack_q, ack_d;
  logic [ACC_W-1:0]    out_q, out_d;
  logic                valid_q, valid_d;
  logic                osat_q, osat_d;
  logic                busy_q, busy_d;

  logic [SUM_W-1:0]    sum_c;
  logic                ovf_c;
  logic [ACC_W-1:0]    clamp_c;
  logic                new_req_c;
  logic                last_c;

  // Next-state, datapath and output logic
  always_comb begin
    state_d    = state_q;
    req_last_d = req_last_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    len_d      = len_q;
    ack_d      = ack_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    osat_d     = osat_q;

    // One extra bit on the sum catches overflow before clamping
    sum_c     = {1'b0, acc_q} + SUM_W'(prod_q);
    ovf_c     = sum_c[ACC_W];
    clamp_c   = ovf_c ? '1 : sum_c[ACC_W-1:0];
    // req_last only moves on acceptance, so edges seen while busy stay pending
    new_req_c = (req_sync != req_last_q);
    last_c    = ((cnt_q + CNT_W'(1)) == len_q);

    case (state_q)
      S_IDLE: begin
        if (new_req_c) begin
          a_d        = a_in;
          b_d        = b_in;
          req_last_d = req_sync;
          if (cnt_q == '0) begin
            len_d = (frame_len == '0) ? CNT_W'(1) : frame_len;
          end
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d  = PROD_W'(a_q) * PROD_W'(b_q);
        state_d = S_ACC;
      end
      S_ACC: begin
        ack_d = ~ack_q;
        if (last_c) begin
          out_d   = clamp_c;
          osat_d  = sat_q | ovf_c;
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          acc_d = clamp_c;
          cnt_d = cnt_q + CNT_W'(1);
          sat_d = sat_q | ovf_c;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_B or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_last_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      len_q      <= '0;
      ack_q      <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      osat_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_last_q <= req_last_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      len_q      <= len_d;
      ack_q      <= ack_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      osat_q     <= osat_d;
      busy_q     <= busy_d;
    end
  end

  assign ack_tgl   = ack_q;
  assign acc_out   = out_q;
  assign acc_valid = valid_q;
  assign acc_sat   = osat_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_toggle_rx_mac.sv
// Bench for toggle_rx_mac: two instances (ACC_W=20 and ACC_W=16) share one
// stimulus stream so the saturating width can be exercised alongside the
// default one. A frame-level arithmetic model predicts every result.
module tb_toggle_rx_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [7:0]  a, b;
  logic [3:0]  fl;

  logic        ack0, val0, sat0, busy0;
  logic [19:0] out0;
  logic        ack1, val1, sat1, busy1;
  logic [15:0] out1;

  always #5 clk = ~clk;

  toggle_rx_mac #(.DATA_W(8), .ACC_W(20), .CNT_W(4)) u_dut20 (
    .clk_B(clk), .rst_n(rst_n), .req_sync(req), .a_in(a), .b_in(b),
    .frame_len(fl), .ack_tgl(ack0), .acc_out(out0), .acc_valid(val0),
    .acc_sat(sat0), .busy(busy0)
  );

  toggle_rx_mac #(.DATA_W(8), .ACC_W(16), .CNT_W(4)) u_dut16 (
    .clk_B(clk), .rst_n(rst_n), .req_sync(req), .a_in(a), .b_in(b),
    .frame_len(fl), .ack_tgl(ack1), .acc_out(out1), .acc_valid(val1),
    .acc_sat(sat1), .busy(busy1)
  );

  typedef struct packed {
    logic        v0;
    logic [19:0] o0;
    logic        s0;
    logic        v1;
    logic [15:0] o1;
    logic        s1;
  } res_t;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (frame arithmetic) ----------------
  localparam longint MAX20 = (longint'(1) << 20) - 1;
  localparam longint MAX16 = (longint'(1) << 16) - 1;

  longint      m_acc20, m_acc16;
  bit          m_sat20, m_sat16;
  int unsigned m_cnt, m_len, m_pairs;
  res_t        last_exp;
  res_t        exp_q[$];
  res_t        got_q[$];

  function automatic void model_reset();
    m_acc20 = 0; m_acc16 = 0; m_sat20 = 0; m_sat16 = 0;
    m_cnt = 0; m_len = 0; m_pairs = 0;
    last_exp = '0;
  endfunction

  function automatic void model_pair(int unsigned av, int unsigned bv, int unsigned flen);
    longint p;
    res_t   r;
    p = longint'(av) * longint'(bv);
    if (m_cnt == 0) m_len = (flen == 0) ? 1 : flen;
    m_acc20 += p;
    if (m_acc20 > MAX20) begin m_acc20 = MAX20; m_sat20 = 1; end
    m_acc16 += p;
    if (m_acc16 > MAX16) begin m_acc16 = MAX16; m_sat16 = 1; end
    m_cnt++;
    m_pairs++;
    if (m_cnt == m_len) begin
      r.v0 = 1'b1; r.o0 = 20'(m_acc20); r.s0 = m_sat20;
      r.v1 = 1'b1; r.o1 = 16'(m_acc16); r.s1 = m_sat16;
      exp_q.push_back(r);
      last_exp = r;
      m_acc20 = 0; m_acc16 = 0; m_sat20 = 0; m_sat16 = 0; m_cnt = 0;
    end
  endfunction

  // ---------------- result monitor ----------------
  int  dbl_valid = 0;
  bit  pv0 = 1'b0, pv1 = 1'b0;
  always @(negedge clk) begin
    if (val0 || val1) got_q.push_back('{val0, out0, sat0, val1, out1, sat1});
    if ((val0 && pv0) || (val1 && pv1)) dbl_valid++;
    pv0 = val0;
    pv1 = val1;
  end

  // ---------------- stimulus driver ----------------
  int lat;
  bit busy_ok;

  // Called at a negedge with the DUT idle; returns at the negedge the ack flipped.
  task automatic send_pair(input int unsigned av, input int unsigned bv);
    logic ack_prev;
    ack_prev = ack0;
    a = 8'(av);
    b = 8'(bv);
    model_pair(av, bv, int'(fl));
    req = ~req;
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack0 !== ack_prev) begin
        lat = i;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy0 !== 1'b1 || busy1 !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; a = '0; b = '0; fl = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, val0, sat0, busy0, ack1, val1, sat1, busy1} !== 8'h0 || out0 !== 20'h0 || out1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_in: outputs during reset ack=%b val=%b out=%0d busy=%b, expected all 0", ack0, val0, out0, busy0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({ack0, val0, sat0, busy0, ack1, val1, sat1, busy1} !== 8'h0 || out0 !== 20'h0 || out1 !== 16'h0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: ack=%b val=%b out=%0d sat=%b busy=%b, expected all 0", i, ack0, val0, out0, sat0, busy0);
      end
    end
  endtask

  task automatic test_single();
    got_q.delete(); exp_q.delete();
    fl = 4'd1;
    send_pair(3, 5);
    checks++;
    if (lat !== 3 || !busy_ok) begin
      errors++;
      $display("FAIL single_latency: ack after %0d cycles busy_ok=%b, expected 3 and 1", lat, busy_ok);
    end
    checks++;
    if (val0 !== 1'b1 || out0 !== 20'd15 || sat0 !== 1'b0 || ack0 !== 1'b1) begin
      errors++;
      $display("FAIL single_value: val=%b out=%0d sat=%b ack=%b, expected 1 15 0 1", val0, out0, sat0, ack0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: %0d results, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_result[%0d]: got %0d/%b %0d/%b expected %0d/%b %0d/%b", i,
                 got_q[i].o0, got_q[i].s0, got_q[i].o1, got_q[i].s1, exp_q[i].o0, exp_q[i].s0, exp_q[i].o1, exp_q[i].s1);
      end
    end
  endtask

  task automatic test_frame4();
    logic [19:0] prev;
    got_q.delete(); exp_q.delete();
    prev = last_exp.o0;
    fl = 4'd4;
    for (int k = 0; k < 4; k++) begin
      send_pair(2 * k + 1, 2 * k + 2);
      checks++;
      if (lat !== 3 || !busy_ok) begin
        errors++;
        $display("FAIL frame4_latency[%0d]: ack after %0d cycles busy_ok=%b, expected 3 and 1", k, lat, busy_ok);
      end
      if (k == 2) begin
        checks++;
        if (out0 !== prev || val0 !== 1'b0) begin
          errors++;
          $display("FAIL frame4_hold: out=%0d val=%b, expected %0d 0", out0, val0, prev);
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || out0 !== 20'd100 || ack0 !== m_pairs[0]) begin
      errors++;
      $display("FAIL frame4_value: %0d results out=%0d ack=%b, expected 1 result 100 ack=%b", got_q.size(), out0, ack0, m_pairs[0]);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame4_count: %0d results, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL frame4_result[%0d]: got %0d/%b %0d/%b expected %0d/%b %0d/%b", i,
                 got_q[i].o0, got_q[i].s0, got_q[i].o1, got_q[i].s1, exp_q[i].o0, exp_q[i].s0, exp_q[i].o1, exp_q[i].s1);
      end
    end
  endtask

  task automatic test_saturate();
    got_q.delete(); exp_q.delete();
    fl = 4'd2;
    send_pair(255, 255);
    send_pair(255, 255);
    fl = 4'd1;
    send_pair(1, 1);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL sat_count: %0d results, expected 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].o1 !== 16'hFFFF || got_q[0].s1 !== 1'b1 || got_q[0].o0 !== 20'd130050 || got_q[0].s0 !== 1'b0) begin
        errors++;
        $display("FAIL sat_clamp: w16 %0d/%b w20 %0d/%b, expected 65535/1 130050/0", got_q[0].o1, got_q[0].s1, got_q[0].o0, got_q[0].s0);
      end
      checks++;
      if (got_q[1].o1 !== 16'd1 || got_q[1].s1 !== 1'b0) begin
        errors++;
        $display("FAIL sat_clear: w16 %0d/%b, expected 1/0", got_q[1].o1, got_q[1].s1);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL sat_result[%0d]: got %0d/%b %0d/%b expected %0d/%b %0d/%b", i,
                   got_q[i].o0, got_q[i].s0, got_q[i].o1, got_q[i].s1, exp_q[i].o0, exp_q[i].s0, exp_q[i].o1, exp_q[i].s1);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    got_q.delete(); exp_q.delete();
    fl = 4'd0;
    send_pair(2, 9);
    fl = 4'd2;
    send_pair(1, 1);
    fl = 4'd3;
    send_pair(2, 2);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL len_count: %0d results, expected 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].o0 !== 20'd18 || got_q[1].o0 !== 20'd5) begin
        errors++;
        $display("FAIL len_values: %0d %0d, expected 18 5", got_q[0].o0, got_q[1].o0);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL len_result[%0d]: got %0d/%b expected %0d/%b", i, got_q[i].o0, got_q[i].s0, exp_q[i].o0, exp_q[i].s0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ack_prev;
    int   t1, t2;
    got_q.delete(); exp_q.delete();
    fl = 4'd2;
    ack_prev = ack0;
    t1 = -1; t2 = -1;
    a = 8'd10; b = 8'd20;
    model_pair(10, 20, int'(fl));
    req = ~req;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b, expected 1", busy0);
    end
    // Second request raised while the first pair is still in flight
    a = 8'd30; b = 8'd40;
    model_pair(30, 40, int'(fl));
    req = ~req;
    for (int i = 2; i <= 20 && t2 < 0; i++) begin
      @(negedge clk);
      if (ack0 !== ack_prev) begin
        if (t1 < 0) t1 = i; else t2 = i;
        ack_prev = ack0;
      end
    end
    checks++;
    if (t1 !== 3 || t2 !== 6) begin
      errors++;
      $display("FAIL b2b_timing: acks at cycles %0d and %0d, expected 3 and 6", t1, t2);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || out0 !== 20'd1400) begin
      errors++;
      $display("FAIL b2b_value: %0d results out=%0d, expected 1 result 1400", got_q.size(), out0);
    end
  endtask

  task automatic test_random();
    int unsigned lo;
    got_q.delete(); exp_q.delete();
    for (int f = 0; f < 8; f++) begin
      fl = 4'($urandom_range(0, 15));
      lo = (f % 2 == 0) ? 0 : 180;
      do begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 3) == 0) fl = 4'($urandom_range(0, 15));
        send_pair($urandom_range(lo, 255), $urandom_range(lo, 255));
        checks++;
        if (lat !== 3 || !busy_ok) begin
          errors++;
          $display("FAIL rand_latency[%0d]: ack after %0d cycles busy_ok=%b, expected 3 and 1", f, lat, busy_ok);
        end
      end while (m_cnt != 0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: %0d results, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %0d/%b %0d/%b expected %0d/%b %0d/%b", i,
                 got_q[i].o0, got_q[i].s0, got_q[i].o1, got_q[i].s1, exp_q[i].o0, exp_q[i].s0, exp_q[i].o1, exp_q[i].s1);
      end
    end
    checks++;
    if (ack0 !== m_pairs[0] || ack1 !== m_pairs[0]) begin
      errors++;
      $display("FAIL rand_ack: ack=%b/%b, expected %b", ack0, ack1, m_pairs[0]);
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); exp_q.delete();
    fl = 4'd3;
    send_pair(5, 5);
    send_pair(6, 6);
    apply_reset();
    checks++;
    if (ack0 !== 1'b0 || busy0 !== 1'b0 || out0 !== 20'h0 || val0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: ack=%b busy=%b out=%0d val=%b, expected all 0", ack0, busy0, out0, val0);
    end
    fl = 4'd1;
    send_pair(4, 4);
    checks++;
    if (lat !== 3 || out0 !== 20'd16 || ack0 !== 1'b1 || sat0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_value: lat=%0d out=%0d ack=%b sat=%b, expected 3 16 1 0", lat, out0, ack0, sat0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count: %0d results, expected 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL rstmid_result: got %0d/%b expected %0d/%b", got_q[0].o0, got_q[0].s0, exp_q[0].o0, exp_q[0].s0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame4();
    test_saturate();
    test_len_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    checks++;
    if (dbl_valid !== 0) begin
      errors++;
      $display("FAIL valid_pulse: %0d consecutive-valid cycles, expected 0", dbl_valid);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_rx_mac.md
# toggle_rx_mac

Receive-side stage in the clk_B domain, directly downstream of the 2-FF toggle synchronizer. It turns each transition of the synchronized request toggle into one accepted operand pair from a bundled-data bus sourced in clk_A. It multiplies and accumulates the pairs over a programmable frame length, returns an acknowledge toggle for resynchronization back into clk_A, and emits one accumulated result per frame.

## Interface
- DATA_W, 8, width of each unsigned operand
- ACC_W, 20, accumulator/result width; must be >= 2*DATA_W
- CNT_W, 4, width of frame length and pair counter
- clk_B  in  1  receive-domain clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_sync  in  1  request toggle, already through the 2-FF synchronizer; each transition = one new pair
- a_in  in  DATA_W  operand A, bundled data from clk_A, stable from before req toggle until ack toggle returns
- b_in  in  DATA_W  operand B, same bundling rule as a_in
- frame_len  in  CNT_W  pairs per result; sampled at first pair of a frame; 0 treated as 1
- ack_tgl  out  1  acknowledge toggle, flips once per accepted pair
- acc_out  out  ACC_W  frame result, held until next frame completes
- acc_valid  out  1  one-cycle pulse when acc_out updates
- acc_sat  out  1  valid with acc_out; 1 if any saturation occurred in that frame
- busy  out  1  high in MUL and ACC states

## Operation
- req_d: registered copy of req_sync, updated only on acceptance; new request = (req_sync != req_d) while in IDLE.
- FSM states: IDLE, MUL, ACC.
- IDLE: on new request, capture a_q<=a_in, b_q<=b_in, req_d<=req_sync; if cnt==0 latch len_q<=max(frame_len,1); go MUL. Otherwise stay.
- MUL: prod <= a_q*b_q (2*DATA_W unsigned); go ACC.
- ACC: sum = acc + zero-extended prod; if sum > 2^ACC_W-1, clamp to all ones and set sticky sat_q. ack_tgl flips. cnt increments.
  - If cnt+1 == len_q: acc_out <= clamped sum, acc_sat <= sat_q|overflow-this-cycle, acc_valid=1, then acc, cnt, sat_q cleared.
  - Else acc <= clamped sum.
  - Go IDLE.
- Requests arriving while busy remain pending, because req_d is not updated. They are accepted on the first IDLE cycle.
- Two req_sync transitions while busy cancel each other and are lost. This is a protocol violation; the source must wait for ack before toggling again.
- frame_len changes mid-frame have no effect until the next frame's first pair.

## Timing
- Reset (async assert, sync release): state IDLE; req_d, a_q, b_q, prod, acc, cnt, sat_q, len_q = 0; ack_tgl=0, acc_out=0, acc_valid=0, acc_sat=0, busy=0.
- Source toggle also resets to 0, so no request appears after reset.
- Acceptance edge E (IDLE, req_sync != req_d): operands captured at E; busy high E+1..E+2.
- ack_tgl flips and, on the frame's last pair, acc_out/acc_valid/acc_sat update at edge E+2.
- Next acceptance at E+3 at earliest (3-cycle pair interval); back-to-back pending request accepted at E+3.
- Reset mid-operation: frame aborted, partial sum discarded, no ack sent; both domains must be reset together.
- acc_valid is never high for more than one consecutive cycle.

## Test plan
- Reset, then hold req_sync=0 for 20 cycles -> no acc_valid, ack_tgl=0, busy=0, all outputs 0.
- frame_len=1; toggle req with a=3, b=5 -> ack_tgl=1 and acc_out=15 with acc_valid pulse exactly 2 cycles after acceptance; acc_sat=0.
- frame_len=4; pairs (1,2),(3,4),(5,6),(7,8) with the source waiting on ack each time -> exactly one acc_valid, acc_out=100; ack_tgl toggled 4 times.
- ACC_W=16, frame_len=2; pairs (255,255),(255,255) -> acc_out=65535, acc_sat=1; next frame (1,1) with frame_len=1 -> acc_out=1, acc_sat=0.
- frame_len=0; pair (2,9) -> treated as length 1, acc_out=18. Then set frame_len=3 mid-frame of a length-2 frame -> result after 2 pairs.
- Start a 3-pair frame; assert rst_n low after the 2nd ack; release and send one pair (4,4) with frame_len=1 -> acc_out=16, earlier partials absent, ack_tgl restarts from 0.
